mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
// - Shares one single-ported, variable-latency memory between the IF stage (instruction fetch)
//   and the MEM stage (load/store) of the pipelined LEGv8 core.
// - Issues one transaction at a time and returns the read data to the winning requester.
// - Drives the per-stage stall lines that, together with the hazard unit, freeze the pipeline.
// - A watchdog aborts any memory access that never completes.
// PARAMETERS
// - AW       64  address width (byte address)
// - DW       64  data width (instruction fetch uses rdata[31:0])
// - TIMEOUT  16  wait cycles allowed per access before abort; legal range 1..255
// PORTS
// - clk        in   1   single clock; all state changes on the rising edge
// - reset      in   1   asynchronous, active-low (0 = reset)
// - i_req      in   1   IF fetch request; held until i_ack
// - i_addr     in   AW  fetch address; stable while i_req=1
// - i_rdata    out  DW  fetch data; valid when i_ack=1
// - i_ack      out  1   one-cycle completion pulse for IF
// - d_req      in   1   MEM access request; held until d_ack
// - d_we       in   1   1 = store, 0 = load
// - d_addr     in   AW  data address
// - d_wdata    in   DW  store data
// - d_rdata    out  DW  load data; valid when d_ack=1
// - d_ack      out  1   one-cycle completion pulse for MEM
// - if_stall   out  1   i_req & ~i_ack
// - mem_stall  out  1   d_req & ~d_ack
// - m_req      out  1   memory request
// - m_we       out  1   memory write enable
// - m_addr     out  AW  memory address
// - m_wdata    out  DW  memory write data
// - m_rdata    in   DW  memory read data; valid in the m_ready cycle
// - m_ready    in   1   memory completion; sampled only while m_req=1
// - err        out  1   sticky timeout flag; cleared only by reset
// BEHAVIOUR
// - Reset: state IDLE; all outputs and registers 0 (m_req, m_we, m_addr, m_wdata, i/d_rdata,
//   i/d_ack, err); watchdog counter 0. Asserting reset mid-transaction drops m_req at once.
//   No ack is given for the aborted access.
// - FSM states:
//   - IDLE:
//     - d_req=1 (after masking) -> register d_we/d_addr/d_wdata onto m_*, set m_req=1, go to D_WAIT.
//     - Otherwise i_req=1 (after masking) -> m_we=0, m_addr=i_addr, m_req=1, go to I_WAIT.
//   - D_WAIT / I_WAIT: m_* held stable.
//     - m_ready=1 -> m_req=0, latch m_rdata into d_rdata/i_rdata, pulse d_ack/i_ack next cycle,
//       go to IDLE.
//   - Watchdog: counter increments each WAIT cycle with m_ready=0.
//     - When the counter reaches TIMEOUT -> m_req=0, pulse the matching ack with rdata=0,
//       set err=1, go to IDLE.
//     - Counter clears on every entry to IDLE.
// - Priority: MEM strictly over IF; MEM holds the older instruction, so this order is needed
//   to avoid deadlock. IF can only wait while MEM is busy.
// - Latency: request seen in IDLE at cycle t -> m_req high from t+1 -> m_ready at t+1+k ->
//   ack at t+2+k. Minimum 2 cycles (k=0).
// - Ack masking: during the ack cycle, the acked requester's req is ignored in IDLE.
//   This avoids a double issue while the requester is dropping req. The other requester may be
//   granted in that same cycle.
// - Stores: d_rdata is still updated with m_rdata (don't-care for the pipeline); d_ack pulses
//   as for loads.
// - m_ready while m_req=0 is ignored. Stall outputs are combinational from req and registered ack.
// - rdata registers hold their last value between acks.
// TESTING
// - Reset: reset=0 with i_req=d_req=1 -> m_req=0, acks=0, err=0. Release reset -> m_req=1 for
//   D first, with m_addr=d_addr.
// - Single fetch: i_req, i_addr=0x40; m_ready after 3 cycles with m_rdata=0x8B020020 ->
//   i_ack 1 cycle later with i_rdata=0x8B020020; if_stall drops with the ack.
// - Simultaneous: i_req and d_req (load 0x100) in the same cycle -> data access first, d_ack.
//   Then the fetch issues in the d_ack cycle, and i_ack follows; no double issue.
// - Store: d_we=1, d_addr=0x18, d_wdata=0xDEAD -> m_we=1, m_wdata=0xDEAD stable until m_ready.
//   d_ack follows; mem_stall is high until then.
// - Timeout: TIMEOUT=16, m_ready held 0 -> m_req drops after 16 wait cycles, d_ack with
//   d_rdata=0, err=1 sticky. The next request is still served normally.
// - Reset mid-access: drive reset=0 during I_WAIT -> m_req=0 at once, no i_ack. After release,
//   the still-held i_req is reissued.

Source files
------------

// File: rtl/mem_port_arbiter.sv
`timescale 1ns/1ps
// mem_port_arbiter: shares one single-ported, variable-latency memory between IF and MEM.
// MEM always wins, one access is in flight at a time, and a watchdog aborts accesses that never complete.
module mem_port_arbiter #(
  parameter int AW      = 64,
  parameter int DW      = 64,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_rdata,
  output logic          i_ack,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ack,
  output logic          if_stall,
  output logic          mem_stall,
  output logic          m_req,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  input  logic          m_ready,
  output logic          err
);
  typedef enum logic [1:0] {IDLE, D_WAIT, I_WAIT} state_t;

  localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT);

  state_t        state_reg, state_next;
  logic [7:0]    wd_cnt_reg, wd_cnt_next;
  logic          m_req_reg, m_req_next;
  logic          m_we_reg, m_we_next;
  logic [AW-1:0] m_addr_reg, m_addr_next;
  logic [DW-1:0] m_wdata_reg, m_wdata_next;
  logic [DW-1:0] i_rdata_reg, i_rdata_next;
  logic [DW-1:0] d_rdata_reg, d_rdata_next;
  logic          i_ack_reg, i_ack_next;
  logic          d_ack_reg, d_ack_next;
  logic          err_reg, err_next;

  // A requester just acked is still dropping its req, so it is ignored for that one cycle.
  logic d_go, i_go, wd_hit;
  assign d_go   = d_req & ~d_ack_reg;
  assign i_go   = i_req & ~i_ack_reg;
  assign wd_hit = (wd_cnt_reg + 8'd1) == TO_LIMIT;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= IDLE;
      wd_cnt_reg  <= '0;
      m_req_reg   <= 1'b0;
      m_we_reg    <= 1'b0;
      m_addr_reg  <= '0;
      m_wdata_reg <= '0;
      i_rdata_reg <= '0;
      d_rdata_reg <= '0;
      i_ack_reg   <= 1'b0;
      d_ack_reg   <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      wd_cnt_reg  <= wd_cnt_next;
      m_req_reg   <= m_req_next;
      m_we_reg    <= m_we_next;
      m_addr_reg  <= m_addr_next;
      m_wdata_reg <= m_wdata_next;
      i_rdata_reg <= i_rdata_next;
      d_rdata_reg <= d_rdata_next;
      i_ack_reg   <= i_ack_next;
      d_ack_reg   <= d_ack_next;
      err_reg     <= err_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    wd_cnt_next  = wd_cnt_reg;
    m_req_next   = m_req_reg;
    m_we_next    = m_we_reg;
    m_addr_next  = m_addr_reg;
    m_wdata_next = m_wdata_reg;
    i_rdata_next = i_rdata_reg;
    d_rdata_next = d_rdata_reg;
    i_ack_next   = 1'b0;
    d_ack_next   = 1'b0;
    err_next     = err_reg;
    case (state_reg)
      IDLE: begin
        wd_cnt_next = '0;
        if (d_go) begin
          m_req_next   = 1'b1;
          m_we_next    = d_we;
          m_addr_next  = d_addr;
          m_wdata_next = d_wdata;
          state_next   = D_WAIT;
        end else if (i_go) begin
          m_req_next  = 1'b1;
          m_we_next   = 1'b0;
          m_addr_next = i_addr;
          state_next  = I_WAIT;
        end
      end
      D_WAIT, I_WAIT: begin
        if (m_ready || wd_hit) begin
          // Completion or abort: an aborted access returns zero data and flags err.
          m_req_next  = 1'b0;
          wd_cnt_next = '0;
          state_next  = IDLE;
          if (state_reg == D_WAIT) begin
            d_ack_next   = 1'b1;
            d_rdata_next = m_ready ? m_rdata : '0;
          end else begin
            i_ack_next   = 1'b1;
            i_rdata_next = m_ready ? m_rdata : '0;
          end
          if (!m_ready) err_next = 1'b1;
        end else begin
          wd_cnt_next = wd_cnt_reg + 8'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign m_req     = m_req_reg;
  assign m_we      = m_we_reg;
  assign m_addr    = m_addr_reg;
  assign m_wdata   = m_wdata_reg;
  assign i_rdata   = i_rdata_reg;
  assign d_rdata   = d_rdata_reg;
  assign i_ack     = i_ack_reg;
  assign d_ack     = d_ack_reg;
  assign err       = err_reg;
  assign if_stall  = i_req & ~i_ack_reg;
  assign mem_stall = d_req & ~d_ack_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
// Bench for mem_port_arbiter: bench-side requesters and memory, predicted by a transaction
// schedule (issue cycle + memory latency -> m_req window and ack cycle).
module tb_mem_port_arbiter;
  localparam int AW      = 64;
  localparam int DW      = 64;
  localparam int TIMEOUT = 16;
  localparam int NEVER   = TIMEOUT + 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          i_req = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic [DW-1:0] i_rdata;
  logic          i_ack;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic [DW-1:0] d_rdata;
  logic          d_ack;
  logic          if_stall;
  logic          mem_stall;
  logic          m_req;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata = '0;
  logic          m_ready = 1'b0;
  logic          err;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .if_stall(if_stall), .mem_stall(mem_stall),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ready(m_ready), .err(err)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Scheduled transaction: m_req high for cycles [tx_start, tx_ack), ack at tx_ack.
  bit            tx_valid = 1'b0;
  bit            tx_is_d;
  int            tx_start, tx_k, tx_ack;
  logic          tx_we;
  logic [AW-1:0] tx_addr;
  logic [DW-1:0] tx_wdata, tx_rdata;
  logic [DW-1:0] exp_i_rdata = '0;
  logic [DW-1:0] exp_d_rdata = '0;
  bit            exp_err = 1'b0;
  bit            cur_i_ack = 1'b0;
  bit            cur_d_ack = 1'b0;

  bit            auto_en = 1'b0;
  int            force_k = -1;
  bit            force_rdata_en = 1'b0;
  logic [DW-1:0] force_rdata;
  bit            want_i = 1'b0;
  bit            want_d = 1'b0;
  logic [AW-1:0] want_i_addr, want_d_addr;
  logic          want_d_we;
  logic [DW-1:0] want_d_wdata;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [63:0] rand64();
    logic [63:0] v;
    v = {$urandom(), $urandom()};
    return v;
  endfunction

  task automatic check_cycle();
    bit in_win;
    in_win    = tx_valid && cyc >= tx_start && cyc < tx_ack;
    cur_i_ack = tx_valid && cyc == tx_ack && !tx_is_d;
    cur_d_ack = tx_valid && cyc == tx_ack && tx_is_d;
    if (cur_i_ack) exp_i_rdata = tx_rdata;
    if (cur_d_ack) exp_d_rdata = tx_rdata;
    if ((cur_i_ack || cur_d_ack) && tx_k >= TIMEOUT) exp_err = 1'b1;
    check_eq("m_req", m_req, in_win);
    if (in_win) begin
      check_eq("m_we", m_we, tx_we);
      check_eq("m_addr", m_addr, tx_addr);
      if (tx_is_d) check_eq("m_wdata", m_wdata, tx_wdata);
    end
    check_eq("i_ack", i_ack, cur_i_ack);
    check_eq("d_ack", d_ack, cur_d_ack);
    check_eq("i_rdata", i_rdata, exp_i_rdata);
    check_eq("d_rdata", d_rdata, exp_d_rdata);
    check_eq("err", err, exp_err);
  endtask

  task automatic drive_cycle();
    bit in_win, d_ok, i_ok;
    int r;
    in_win = tx_valid && cyc >= tx_start && cyc < tx_ack;
    // Requesters: drop (or re-request) on ack, otherwise hold; idle ones may start a new request.
    if (cur_i_ack) begin
      if (auto_en && $urandom_range(0, 1) == 1) i_addr = rand64();
      else i_req = 1'b0;
    end else if (!i_req) begin
      if (want_i) begin
        i_req = 1'b1; i_addr = want_i_addr; want_i = 1'b0;
      end else if (auto_en && $urandom_range(0, 3) == 0) begin
        i_req = 1'b1; i_addr = rand64();
      end
    end
    if (cur_d_ack) begin
      if (auto_en && $urandom_range(0, 1) == 1) begin
        d_we = 1'($urandom_range(0, 1)); d_addr = rand64(); d_wdata = rand64();
      end else d_req = 1'b0;
    end else if (!d_req) begin
      if (want_d) begin
        d_req = 1'b1; d_we = want_d_we; d_addr = want_d_addr; d_wdata = want_d_wdata;
        want_d = 1'b0;
      end else if (auto_en && $urandom_range(0, 3) == 0) begin
        d_req = 1'b1; d_we = 1'($urandom_range(0, 1)); d_addr = rand64(); d_wdata = rand64();
      end
    end
    // Memory: ready exactly k cycles into the window; random noise on m_ready outside it.
    m_rdata = rand64();
    if (in_win) begin
      m_ready = (cyc == tx_start + tx_k);
      if (m_ready) begin
        if (force_rdata_en) begin
          m_rdata = force_rdata; force_rdata_en = 1'b0;
        end
        tx_rdata = m_rdata;
      end
    end else begin
      m_ready = ($urandom_range(0, 2) == 0);
    end
    // Arbitration: the port is free outside a window, including the ack cycle.
    if (!tx_valid || cyc >= tx_ack) begin
      d_ok = d_req && !cur_d_ack;
      i_ok = i_req && !cur_i_ack;
      if (d_ok || i_ok) begin
        tx_valid = 1'b1;
        tx_is_d  = d_ok;
        tx_start = cyc + 1;
        tx_we    = d_ok ? d_we : 1'b0;
        tx_addr  = d_ok ? d_addr : i_addr;
        tx_wdata = d_wdata;
        tx_rdata = '0;
        if (force_k >= 0) begin
          tx_k = force_k; force_k = -1;
        end else begin
          r = int'($urandom_range(0, 19));
          tx_k = (r == 0) ? TIMEOUT - 1 : (r == 1) ? NEVER : int'($urandom_range(0, 4));
        end
        tx_ack = (tx_k < TIMEOUT) ? tx_start + tx_k + 1 : tx_start + TIMEOUT;
      end
    end
    #1;
    check_eq("if_stall", if_stall, i_req && !cur_i_ack);
    check_eq("mem_stall", mem_stall, d_req && !cur_d_ack);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    check_cycle();
    drive_cycle();
  endtask

  task automatic do_reset(input int n);
    reset = 1'b0;
    #1;
    tx_valid = 1'b0; exp_err = 1'b0; exp_i_rdata = '0; exp_d_rdata = '0;
    cur_i_ack = 1'b0; cur_d_ack = 1'b0;
    check_eq("rst_async_m_req", m_req, 1'b0);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      check_eq("rst_m_req", m_req, 1'b0);
      check_eq("rst_m_we", m_we, 1'b0);
      check_eq("rst_m_addr", m_addr, 64'd0);
      check_eq("rst_m_wdata", m_wdata, 64'd0);
      check_eq("rst_i_ack", i_ack, 1'b0);
      check_eq("rst_d_ack", d_ack, 1'b0);
      check_eq("rst_i_rdata", i_rdata, 64'd0);
      check_eq("rst_d_rdata", d_rdata, 64'd0);
      check_eq("rst_err", err, 1'b0);
    end
    reset = 1'b1;
    drive_cycle();
  endtask

  task automatic run_until_quiet(input int max_cycles);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while ((i_req || d_req || want_i || want_d || (tx_valid && cyc < tx_ack)) && n < max_cycles);
    check_eq("wait_bound_expired", (n >= max_cycles), 1'b0);
  endtask

  initial begin
    // Reset with both requests pending; data side must go first on release.
    i_req = 1'b1; i_addr = 64'h1000;
    d_req = 1'b1; d_we = 1'b0; d_addr = 64'h2000; d_wdata = 64'h0;
    force_k = 2;
    do_reset(3);
    step();
    check_eq("rst_d_first_req", m_req, 1'b1);
    check_eq("rst_d_first_addr", m_addr, 64'h2000);
    run_until_quiet(200);

    // Single fetch, memory answers after 3 cycles.
    want_i = 1'b1; want_i_addr = 64'h40;
    force_k = 3; force_rdata_en = 1'b1; force_rdata = 64'h8B020020;
    run_until_quiet(50);
    check_eq("fetch_rdata", i_rdata, 64'h8B020020);

    // Simultaneous fetch and load: load served first, fetch issues in the d_ack cycle.
    want_i = 1'b1; want_i_addr = 64'h44;
    want_d = 1'b1; want_d_we = 1'b0; want_d_addr = 64'h100; want_d_wdata = 64'h0;
    force_k = 1;
    run_until_quiet(80);

    // Store held stable for 5 wait cycles.
    want_d = 1'b1; want_d_we = 1'b1; want_d_addr = 64'h18; want_d_wdata = 64'hDEAD;
    force_k = 5;
    run_until_quiet(50);

    // Latest legal completion: ready on the last wait cycle, no error.
    want_i = 1'b1; want_i_addr = 64'h48;
    force_k = TIMEOUT - 1; force_rdata_en = 1'b1; force_rdata = 64'h1234;
    run_until_quiet(60);
    check_eq("late_ready_err", err, 1'b0);
    check_eq("late_ready_rdata", i_rdata, 64'h1234);

    // Timeout on a load, then a normal fetch with err still set.
    want_d = 1'b1; want_d_we = 1'b0; want_d_addr = 64'h200; want_d_wdata = 64'h0;
    force_k = NEVER;
    run_until_quiet(60);
    check_eq("timeout_err", err, 1'b1);
    check_eq("timeout_rdata", d_rdata, 64'h0);
    want_i = 1'b1; want_i_addr = 64'h4C; force_k = 1;
    run_until_quiet(40);
    check_eq("timeout_sticky", err, 1'b1);

    // Reset during a fetch wait: no ack, request reissued afterwards.
    want_i = 1'b1; want_i_addr = 64'h80; force_k = NEVER;
    repeat (4) step();
    check_eq("mid_rst_busy", m_req, 1'b1);
    do_reset(2);
    run_until_quiet(60);

    // Randomized traffic from both requesters.
    auto_en = 1'b1;
    repeat (4000) step();
    auto_en = 1'b0;
    run_until_quiet(200);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
